mem_write_checker: RTL and testbench
====================================

Name: mem_write_checker

Overview:
- Synthesizable, parametrised memory-write checker for the pipelined MIPS core.
- Watches the core's data-memory write port and compares each write, in order, against a programmed table of up to DEPTH expected (address, data) pairs.
- Writes to a programmable ignore-address window are skipped, not checked.
- Reports pass, fail (with failing index and captured write) or watchdog timeout.
- Replaces the single-pair, fixed-address self-check with a reusable block for benches and FPGA bring-up.

Parameters:
- ADDR_W, 32, width of the monitored data address.
- DATA_W, 32, width of the monitored write data.
- WE_W, 2, width of the memwrite strobe; any nonzero bit marks a write event.
- DEPTH, 8, number of expected-write table entries (power of two, ≥2).
- TIMEOUT_CYCLES, 1000, maximum RUN cycles allowed between consecutive checked matches.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- memwrite  in  WE_W  core write strobe.
- dataadr  in  ADDR_W  core write address.
- writedata  in  DATA_W  core write data.
- exp_we  in  1  table load strobe.
- exp_idx  in  $clog2(DEPTH)  table load index.
- exp_addr  in  ADDR_W  expected address to load.
- exp_data  in  DATA_W  expected data to load.
- num_exp  in  $clog2(DEPTH)+1  number of entries to check.
- ign_en  in  1  ignore window enable.
- ign_addr  in  ADDR_W  ignore window base.
- ign_mask  in  ADDR_W  ignore compare mask (1 = bit compared).
- start  in  1  begin checking (one-cycle pulse).
- busy  out  1  high in RUN.
- done  out  1  high in PASS/FAIL/TIMEOUT.
- pass  out  1  all entries matched.
- fail  out  1  mismatch or bad config.
- timeout  out  1  watchdog expired.
- err_cfg  out  1  num_exp was 0 or >DEPTH at start.
- fail_idx  out  $clog2(DEPTH)  entry index at mismatch.
- fail_addr  out  ADDR_W  captured address of the mismatching write.
- fail_data  out  DATA_W  captured data of the mismatching write.
- match_cnt  out  $clog2(DEPTH)+1  entries matched so far.
- ign_cnt  out  16  ignored writes, saturating at 16'hFFFF.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset state:
  - state=IDLE.
  - All outputs 0, including fail_idx, fail_addr, fail_data, match_cnt and ign_cnt.
  - Pointer and watchdog are 0.
  - Table contents are not reset.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. Outputs are registered and reflect the new state one cycle after the triggering edge.
- Table loading: with exp_we=1 in IDLE, PASS, FAIL or TIMEOUT, table[exp_idx] is written at the edge. exp_we is ignored in RUN.
- Starting a run: start=1 in any non-RUN state:
  - If 1≤num_exp≤DEPTH: latch num_exp, clear ptr, match_cnt, ign_cnt, watchdog and all status/fail fields, then go to RUN.
  - Otherwise: go to FAIL with err_cfg=1 and fail_idx=0.
- start is ignored in RUN. start and exp_we in the same cycle: the load occurs first, so the run sees the new entry.
- RUN event handling, per edge:
  - Event = |memwrite.
  - Ignored = ign_en && ((dataadr & ign_mask) == (ign_addr & ign_mask)).
  - Event and ignored: ign_cnt increments (saturating). Pointer and watchdog are unchanged by the write; the watchdog still counts the cycle.
  - Event and not ignored, with dataadr==table[ptr].addr and writedata==table[ptr].data (all bits; X/Z count as mismatch in simulation): ptr and match_cnt increment and the watchdog clears. If ptr==num_exp-1, go to PASS.
  - Event and not ignored, mismatch: go to FAIL, with fail_idx=ptr and fail_addr/fail_data=the sampled write.
  - No event: the watchdog increments.
- Timeout: watchdog reaching TIMEOUT_CYCLES-1 with no match that cycle → TIMEOUT. A write on that same edge is evaluated first:
  - Match: watchdog clears, stay in RUN (or go to PASS).
  - Mismatch: FAIL wins.
- Terminal states:
  - PASS, FAIL and TIMEOUT are sticky until start or reset.
  - Writes in terminal states are not checked and do not change any output.
- Reset asserted mid-RUN: the next state is IDLE with outputs cleared; the table is preserved.
- Pointer never wraps, because PASS is entered on the last entry.

Test Plan:
- Program table[0]=(84,7), num_exp=1, ign_en=1, ign_addr=80, ign_mask=all-ones, start. Drive writes (80,3), (80,5), (84,7) → ign_cnt=2, then pass=1, done=1, match_cnt=1 one cycle after the third write.
- Same setup, drive (88,7) → fail=1, fail_idx=0, fail_addr=88, fail_data=7. A subsequent (84,7) leaves all outputs unchanged.
- Program four entries (0,1), (4,2), (8,3), (12,4), num_exp=4, ign_en=0. Drive in order, with 3 idle cycles between writes → match_cnt steps 1..4, then pass=1.
- TIMEOUT_CYCLES=16, start with no writes → timeout=1 exactly 16 cycles after entering RUN. Repeat with the matching write on the 16th RUN cycle → no timeout, pass=1.
- start with num_exp=0, and separately with num_exp=DEPTH+1 → fail=1 and err_cfg=1 one cycle later, busy never asserted.
- Assert reset for 1 cycle mid-RUN after 2 of 4 matches → all outputs 0, state IDLE. Re-start → all four entries match and pass=1, with no reload.

Source files
------------

// File: rtl/mem_write_checker.sv
// Memory-write checker: compares the core's data-memory writes, in order,
// against a programmed table of expected (address, data) pairs. Writes that
// fall inside the ignore window are counted but not checked. The result is
// reported as pass, fail (with failing index and captured write) or a
// watchdog timeout when no checked match arrives in time.
module mem_write_checker #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WE_W           = 2,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WE_W-1:0]            memwrite,
    input  logic [ADDR_W-1:0]          dataadr,
    input  logic [DATA_W-1:0]          writedata,
    input  logic                       exp_we,
    input  logic [$clog2(DEPTH)-1:0]   exp_idx,
    input  logic [ADDR_W-1:0]          exp_addr,
    input  logic [DATA_W-1:0]          exp_data,
    input  logic [$clog2(DEPTH):0]     num_exp,
    input  logic                       ign_en,
    input  logic [ADDR_W-1:0]          ign_addr,
    input  logic [ADDR_W-1:0]          ign_mask,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic                       err_cfg,
    output logic [$clog2(DEPTH)-1:0]   fail_idx,
    output logic [ADDR_W-1:0]          fail_addr,
    output logic [DATA_W-1:0]          fail_data,
    output logic [$clog2(DEPTH):0]     match_cnt,
    output logic [15:0]                ign_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_PASS    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Expected-write table (intentionally not reset so it survives a reset)
    logic [ADDR_W-1:0] tbl_addr_r [DEPTH];
    logic [DATA_W-1:0] tbl_data_r [DEPTH];

    logic [2:0]        state_r,     state_nx;
    logic [IDX_W-1:0]  ptr_r,       ptr_nx;
    logic [CNT_W-1:0]  num_r,       num_nx;
    logic [WD_W-1:0]   wd_r,        wd_nx;
    logic [CNT_W-1:0]  match_cnt_r, match_cnt_nx;
    logic [15:0]       ign_cnt_r,   ign_cnt_nx;
    logic [IDX_W-1:0]  fail_idx_r,  fail_idx_nx;
    logic [ADDR_W-1:0] fail_addr_r, fail_addr_nx;
    logic [DATA_W-1:0] fail_data_r, fail_data_nx;
    logic              err_cfg_r,   err_cfg_nx;
    logic              busy_r,      busy_nx;
    logic              done_r,      done_nx;
    logic              pass_r,      pass_nx;
    logic              fail_r,      fail_nx;
    logic              timeout_r,   timeout_nx;

    logic event_s;
    logic ignored_s;
    logic hit_s;
    logic last_s;
    logic cfg_ok_s;

    // Table load: only outside RUN so an active check sees a stable table
    always_ff @(posedge clk) begin
        if (exp_we && (state_r != ST_RUN)) begin
            tbl_addr_r[exp_idx] <= exp_addr;
            tbl_data_r[exp_idx] <= exp_data;
        end
    end

    // Decode of the current write and of the start configuration
    always_comb begin
        event_s   = |memwrite;
        ignored_s = ign_en && ((dataadr & ign_mask) == (ign_addr & ign_mask));
        hit_s     = (dataadr == tbl_addr_r[ptr_r]) && (writedata == tbl_data_r[ptr_r]);
        last_s    = ({1'b0, ptr_r} == (num_r - CNT_W'(1)));
        cfg_ok_s  = (num_exp != {CNT_W{1'b0}}) && (num_exp <= DEPTH_C);
    end

    // Next-state and next-output computation for the checker FSM
    always_comb begin
        state_nx     = state_r;
        ptr_nx       = ptr_r;
        num_nx       = num_r;
        wd_nx        = wd_r;
        match_cnt_nx = match_cnt_r;
        ign_cnt_nx   = ign_cnt_r;
        fail_idx_nx  = fail_idx_r;
        fail_addr_nx = fail_addr_r;
        fail_data_nx = fail_data_r;
        err_cfg_nx   = err_cfg_r;

        case (state_r)
            ST_RUN: begin
                if (event_s && !ignored_s) begin
                    if (hit_s) begin
                        // A checked match always beats the watchdog
                        ptr_nx       = ptr_r + IDX_W'(1);
                        match_cnt_nx = match_cnt_r + CNT_W'(1);
                        wd_nx        = {WD_W{1'b0}};
                        if (last_s) begin
                            state_nx = ST_PASS;
                        end else begin
                            state_nx = ST_RUN;
                        end
                    end else begin
                        state_nx     = ST_FAIL;
                        fail_idx_nx  = ptr_r;
                        fail_addr_nx = dataadr;
                        fail_data_nx = writedata;
                    end
                end else begin
                    // Idle cycle or ignored write: the watchdog keeps running
                    if (event_s) begin
                        if (ign_cnt_r != 16'hFFFF) begin
                            ign_cnt_nx = ign_cnt_r + 16'd1;
                        end else begin
                            ign_cnt_nx = ign_cnt_r;
                        end
                    end else begin
                        ign_cnt_nx = ign_cnt_r;
                    end
                    if (wd_r == WD_LAST) begin
                        state_nx = ST_TIMEOUT;
                    end else begin
                        wd_nx = wd_r + WD_W'(1);
                    end
                end
            end
            ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                if (start) begin
                    ptr_nx       = {IDX_W{1'b0}};
                    wd_nx        = {WD_W{1'b0}};
                    match_cnt_nx = {CNT_W{1'b0}};
                    ign_cnt_nx   = 16'd0;
                    fail_idx_nx  = {IDX_W{1'b0}};
                    fail_addr_nx = {ADDR_W{1'b0}};
                    fail_data_nx = {DATA_W{1'b0}};
                    if (cfg_ok_s) begin
                        state_nx   = ST_RUN;
                        num_nx     = num_exp;
                        err_cfg_nx = 1'b0;
                    end else begin
                        state_nx   = ST_FAIL;
                        num_nx     = {CNT_W{1'b0}};
                        err_cfg_nx = 1'b1;
                    end
                end else begin
                    state_nx = state_r;
                end
            end
            default: begin
                // Unreachable encoding: recover to a quiet IDLE
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx    = (state_nx == ST_RUN);
        pass_nx    = (state_nx == ST_PASS);
        fail_nx    = (state_nx == ST_FAIL);
        timeout_nx = (state_nx == ST_TIMEOUT);
        done_nx    = pass_nx || fail_nx || timeout_nx;
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {IDX_W{1'b0}};
            num_r       <= {CNT_W{1'b0}};
            wd_r        <= {WD_W{1'b0}};
            match_cnt_r <= {CNT_W{1'b0}};
            ign_cnt_r   <= 16'd0;
            fail_idx_r  <= {IDX_W{1'b0}};
            fail_addr_r <= {ADDR_W{1'b0}};
            fail_data_r <= {DATA_W{1'b0}};
            err_cfg_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nx;
            ptr_r       <= ptr_nx;
            num_r       <= num_nx;
            wd_r        <= wd_nx;
            match_cnt_r <= match_cnt_nx;
            ign_cnt_r   <= ign_cnt_nx;
            fail_idx_r  <= fail_idx_nx;
            fail_addr_r <= fail_addr_nx;
            fail_data_r <= fail_data_nx;
            err_cfg_r   <= err_cfg_nx;
            busy_r      <= busy_nx;
            done_r      <= done_nx;
            pass_r      <= pass_nx;
            fail_r      <= fail_nx;
            timeout_r   <= timeout_nx;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign fail      = fail_r;
    assign timeout   = timeout_r;
    assign err_cfg   = err_cfg_r;
    assign fail_idx  = fail_idx_r;
    assign fail_addr = fail_addr_r;
    assign fail_data = fail_data_r;
    assign match_cnt = match_cnt_r;
    assign ign_cnt   = ign_cnt_r;

endmodule

// File: tb/tb_mem_write_checker.sv
// Self-checking bench for mem_write_checker: directed scenarios followed by
// randomized traffic, all compared every cycle against a queue-based model.
module tb_mem_write_checker;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int WEW   = 2;
    localparam int DEPTH = 8;
    localparam int TO    = 16;
    localparam int IW    = $clog2(DEPTH);

    logic            clk = 1'b0;
    logic            reset;
    logic [WEW-1:0]  memwrite;
    logic [AW-1:0]   dataadr;
    logic [DW-1:0]   writedata;
    logic            exp_we;
    logic [IW-1:0]   exp_idx;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_data;
    logic [IW:0]     num_exp;
    logic            ign_en;
    logic [AW-1:0]   ign_addr;
    logic [AW-1:0]   ign_mask;
    logic            start;
    logic            busy, done, pass, fail, timeout, err_cfg;
    logic [IW-1:0]   fail_idx;
    logic [AW-1:0]   fail_addr;
    logic [DW-1:0]   fail_data;
    logic [IW:0]     match_cnt;
    logic [15:0]     ign_cnt;

    always #5 clk = ~clk;

    mem_write_checker #(
        .ADDR_W(AW), .DATA_W(DW), .WE_W(WEW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .num_exp(num_exp),
        .ign_en(ign_en), .ign_addr(ign_addr), .ign_mask(ign_mask), .start(start),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .err_cfg(err_cfg), .fail_idx(fail_idx), .fail_addr(fail_addr),
        .fail_data(fail_data), .match_cnt(match_cnt), .ign_cnt(ign_cnt)
    );

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_RUN, M_PASS, M_FAIL, M_TO} mode_t;
    mode_t         m_mode = M_IDLE;
    logic [AW-1:0] m_addr [DEPTH];
    logic [DW-1:0] m_data [DEPTH];
    int            pend[$];          // table indices still awaiting a write
    int            m_n = 0;          // entries requested for this run
    int            m_idle = 0;       // RUN cycles since the last checked match
    int            m_ign = 0;
    int            m_err = 0;
    int            m_fidx = 0;
    logic [AW-1:0] m_faddr = '0;
    logic [DW-1:0] m_fdata = '0;
    bit            armed = 1'b0;
    int            slow = 0;

    typedef struct { string name; int sel; logic [31:0] expv; } lit_t;
    lit_t lits[$];

    int checks = 0;
    int errors = 0;

    task automatic model_clear();
        pend.delete();
        m_n = 0; m_idle = 0; m_ign = 0; m_err = 0; m_fidx = 0;
        m_faddr = '0; m_fdata = '0;
    endtask

    // Advance the model by one clock edge using the inputs sampled there
    task automatic model_step();
        bit ev, ig;
        if (exp_we && m_mode != M_RUN) begin
            m_addr[exp_idx] = exp_addr;
            m_data[exp_idx] = exp_data;
        end
        if (reset) begin
            m_mode = M_IDLE;
            model_clear();
        end else if (m_mode != M_RUN) begin
            if (start) begin
                model_clear();
                if (int'(num_exp) >= 1 && int'(num_exp) <= DEPTH) begin
                    m_n = int'(num_exp);
                    for (int i = 0; i < m_n; i++) pend.push_back(i);
                    m_mode = M_RUN;
                end else begin
                    m_mode = M_FAIL;
                    m_err  = 1;
                end
            end
        end else begin
            ev = (memwrite != '0);
            ig = ign_en && ((dataadr & ign_mask) == (ign_addr & ign_mask));
            if (ev && !ig) begin
                if (dataadr === m_addr[pend[0]] && writedata === m_data[pend[0]]) begin
                    void'(pend.pop_front());
                    m_idle = 0;
                    if (pend.size() == 0) m_mode = M_PASS;
                end else begin
                    m_fidx  = m_n - pend.size();
                    m_faddr = dataadr;
                    m_fdata = writedata;
                    m_mode  = M_FAIL;
                end
            end else begin
                if (ev && m_ign < 65535) m_ign++;
                m_idle++;
                if (m_idle >= TO) m_mode = M_TO;
            end
        end
    endtask

    function automatic logic [31:0] get_out(input int sel);
        case (sel)
            0:  return 32'(busy);
            1:  return 32'(done);
            2:  return 32'(pass);
            3:  return 32'(fail);
            4:  return 32'(timeout);
            5:  return 32'(err_cfg);
            6:  return 32'(fail_idx);
            7:  return 32'(fail_addr);
            8:  return 32'(fail_data);
            9:  return 32'(match_cnt);
            10: return 32'(ign_cnt);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    // Single compare process: model vs DUT every cycle, plus literal pins
    always begin
        lit_t l;
        @(negedge clk);
        #1;
        if (armed) begin
            cmp("busy",      get_out(0),  32'(m_mode == M_RUN));
            cmp("done",      get_out(1),  32'(m_mode == M_PASS || m_mode == M_FAIL || m_mode == M_TO));
            cmp("pass",      get_out(2),  32'(m_mode == M_PASS));
            cmp("fail",      get_out(3),  32'(m_mode == M_FAIL));
            cmp("timeout",   get_out(4),  32'(m_mode == M_TO));
            cmp("err_cfg",   get_out(5),  32'(m_err));
            cmp("fail_idx",  get_out(6),  32'(m_fidx));
            cmp("fail_addr", get_out(7),  32'(m_faddr));
            cmp("fail_data", get_out(8),  32'(m_fdata));
            cmp("match_cnt", get_out(9),  32'(m_n - pend.size()));
            cmp("ign_cnt",   get_out(10), 32'(m_ign));
            while (lits.size() > 0) begin
                l = lits.pop_front();
                cmp(l.name, get_out(l.sel), l.expv);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic lit(input string nm, input int sel, input logic [31:0] v);
        lit_t t;
        t.name = nm; t.sel = sel; t.expv = v;
        lits.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        armed = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 1'b0; memwrite = '0; exp_we = 1'b0; start = 1'b0;
    endtask

    task automatic load(input int i, input int a, input int d);
        exp_we = 1'b1; exp_idx = IW'(i); exp_addr = AW'(a); exp_data = DW'(d);
        tick();
        exp_we = 1'b0;
    endtask

    task automatic go(input int n);
        num_exp = (IW+1)'(n); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        memwrite = 2'b01; dataadr = AW'(a); writedata = DW'(d);
        tick();
        memwrite = '0;
    endtask

    initial begin
        int r;
        idle_inputs();
        reset = 1'b1;
        dataadr = '0; writedata = '0; exp_idx = '0; exp_addr = '0; exp_data = '0;
        num_exp = '0; ign_en = 1'b0; ign_addr = '0; ign_mask = 32'hFFFF_FFFF;
        tick(); tick();
        lit("rst_busy", 0, 32'd0); lit("rst_done", 1, 32'd0); lit("rst_match", 9, 32'd0);
        reset = 1'b0;

        // Ignored writes, then the single expected write
        load(0, 84, 7);
        ign_en = 1'b1; ign_addr = 32'd80; ign_mask = 32'hFFFF_FFFF;
        go(1);
        lit("t1_busy", 0, 32'd1);
        wr(80, 3); wr(80, 5);
        lit("t1_ign", 10, 32'd2);
        wr(84, 7);
        lit("t1_pass", 2, 32'd1); lit("t1_done", 1, 32'd1); lit("t1_match", 9, 32'd1);

        // Mismatch, then a write in FAIL that must change nothing
        go(1);
        wr(88, 7);
        lit("t2_fail", 3, 32'd1); lit("t2_fidx", 6, 32'd0);
        lit("t2_faddr", 7, 32'd88); lit("t2_fdata", 8, 32'd7);
        wr(84, 7);
        lit("t2_sticky_fail", 3, 32'd1); lit("t2_sticky_pass", 2, 32'd0);
        lit("t2_sticky_addr", 7, 32'd88); lit("t2_sticky_match", 9, 32'd0);

        // Four entries with idle gaps
        ign_en = 1'b0;
        for (int k = 0; k < 4; k++) load(k, 4 * k, k + 1);
        go(4);
        for (int k = 0; k < 4; k++) begin
            tick(); tick(); tick();
            wr(4 * k, k + 1);
            lit("t3_match", 9, 32'(k + 1));
        end
        lit("t3_pass", 2, 32'd1);

        // Watchdog expiry and a last-moment rescue
        go(1);
        for (int k = 0; k < TO - 1; k++) tick();
        lit("t4_no_to_yet", 4, 32'd0); lit("t4_busy", 0, 32'd1);
        tick();
        lit("t4_timeout", 4, 32'd1); lit("t4_done", 1, 32'd1);
        go(1);
        for (int k = 0; k < TO - 1; k++) tick();
        wr(0, 1);
        lit("t4_rescue_pass", 2, 32'd1); lit("t4_rescue_to", 4, 32'd0);

        // Bad configuration
        go(0);
        lit("t5_fail0", 3, 32'd1); lit("t5_err0", 5, 32'd1); lit("t5_busy0", 0, 32'd0);
        go(DEPTH + 1);
        lit("t5_fail9", 3, 32'd1); lit("t5_err9", 5, 32'd1); lit("t5_busy9", 0, 32'd0);

        // Reset mid-run, then re-run on the preserved table
        go(4);
        wr(0, 1); wr(4, 2);
        lit("t6_match2", 9, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lit("t6_busy", 0, 32'd0); lit("t6_match", 9, 32'd0); lit("t6_err", 5, 32'd0);
        lit("t6_done", 1, 32'd0);
        go(4);
        for (int k = 0; k < 4; k++) wr(4 * k, k + 1);
        lit("t6_pass", 2, 32'd1); lit("t6_match4", 9, 32'd4);

        // Randomized traffic
        for (int k = 0; k < DEPTH; k++) load(k, 4 * $urandom_range(0, 15), $urandom_range(0, 3));
        for (int c = 0; c < 4000; c++) begin
            idle_inputs();
            r = $urandom_range(0, 199);
            if (r == 0) begin
                reset = 1'b1;
            end else if (m_mode != M_RUN) begin
                if (r < 80) begin
                    exp_we = 1'b1; exp_idx = IW'($urandom_range(0, DEPTH - 1));
                    exp_addr = AW'(4 * $urandom_range(0, 15)); exp_data = DW'($urandom_range(0, 3));
                end
                if (r >= 50 && r < 100) begin
                    start = 1'b1;
                    if (r < 54) num_exp = ($urandom_range(0, 1) == 0) ? '0 : (IW+1)'(DEPTH + 1);
                    else num_exp = (IW+1)'($urandom_range(1, DEPTH));
                    ign_en = 1'($urandom_range(0, 1));
                    ign_addr = AW'(4 * $urandom_range(0, 15));
                    ign_mask = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFF0;
                    slow = ($urandom_range(0, 3) == 0) ? 1 : 0;
                end
                if (r >= 100 && r < 140) begin
                    memwrite = WEW'($urandom_range(1, 3));
                    dataadr = AW'(4 * $urandom_range(0, 15)); writedata = DW'($urandom_range(0, 3));
                end
            end else begin
                memwrite = WEW'($urandom_range(1, 3));
                if ((slow == 0 && r < 110) || (slow == 1 && r < 8)) begin
                    dataadr = m_addr[pend[0]]; writedata = m_data[pend[0]];
                end else if (r < 130) begin
                    dataadr = ign_addr; writedata = DW'($urandom_range(0, 3));
                end else if (slow == 0 && r < 145) begin
                    dataadr = AW'(4 * $urandom_range(0, 15)); writedata = DW'($urandom_range(0, 3));
                end else begin
                    memwrite = '0;
                end
            end
            tick();
        end

        idle_inputs();
        tick(); tick();
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
